// File: rtl/core_axi_master_bridge_if.sv
// AXI4 bus bundle carrying all five channels.
// The bridge drives it through the Master modport.
interface AXI_BUS #(
    parameter int unsigned AXI_ADDR_WIDTH = 32,
    parameter int unsigned AXI_DATA_WIDTH = 64,
    parameter int unsigned AXI_ID_WIDTH   = 10,
    parameter int unsigned AXI_USER_WIDTH = 10
);
    localparam int unsigned STRB_WIDTH = AXI_DATA_WIDTH / 8;

    logic [AXI_ID_WIDTH-1:0]   aw_id;
    logic [AXI_ADDR_WIDTH-1:0] aw_addr;
    logic [7:0]                aw_len;
    logic [2:0]                aw_size;
    logic [1:0]                aw_burst;
    logic                      aw_lock;
    logic [3:0]                aw_cache;
    logic [2:0]                aw_prot;
    logic [3:0]                aw_region;
    logic [3:0]                aw_qos;
    logic [AXI_USER_WIDTH-1:0] aw_user;
    logic                      aw_valid;
    logic                      aw_ready;

    logic [AXI_DATA_WIDTH-1:0] w_data;
    logic [STRB_WIDTH-1:0]     w_strb;
    logic                      w_last;
    logic [AXI_USER_WIDTH-1:0] w_user;
    logic                      w_valid;
    logic                      w_ready;

    logic [AXI_ID_WIDTH-1:0]   b_id;
    logic [1:0]                b_resp;
    logic [AXI_USER_WIDTH-1:0] b_user;
    logic                      b_valid;
    logic                      b_ready;

    logic [AXI_ID_WIDTH-1:0]   ar_id;
    logic [AXI_ADDR_WIDTH-1:0] ar_addr;
    logic [7:0]                ar_len;
    logic [2:0]                ar_size;
    logic [1:0]                ar_burst;
    logic                      ar_lock;
    logic [3:0]                ar_cache;
    logic [2:0]                ar_prot;
    logic [3:0]                ar_region;
    logic [3:0]                ar_qos;
    logic [AXI_USER_WIDTH-1:0] ar_user;
    logic                      ar_valid;
    logic                      ar_ready;

    logic [AXI_ID_WIDTH-1:0]   r_id;
    logic [AXI_DATA_WIDTH-1:0] r_data;
    logic [1:0]                r_resp;
    logic                      r_last;
    logic [AXI_USER_WIDTH-1:0] r_user;
    logic                      r_valid;
    logic                      r_ready;

    modport Master (
        output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache,
               aw_prot, aw_region, aw_qos, aw_user, aw_valid,
        input  aw_ready,
        output w_data, w_strb, w_last, w_user, w_valid,
        input  w_ready,
        input  b_id, b_resp, b_user, b_valid,
        output b_ready,
        output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache,
               ar_prot, ar_region, ar_qos, ar_user, ar_valid,
        input  ar_ready,
        input  r_id, r_data, r_resp, r_last, r_user, r_valid,
        output r_ready
    );

    modport Slave (
        input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache,
               aw_prot, aw_region, aw_qos, aw_user, aw_valid,
        output aw_ready,
        input  w_data, w_strb, w_last, w_user, w_valid,
        output w_ready,
        output b_id, b_resp, b_user, b_valid,
        input  b_ready,
        input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache,
               ar_prot, ar_region, ar_qos, ar_user, ar_valid,
        output ar_ready,
        output r_id, r_data, r_resp, r_last, r_user, r_valid,
        input  r_ready
    );
endinterface

// File: rtl/core_axi_master_bridge.sv
// Bridges a simple req/gnt/rvalid core memory port onto single-beat AXI4
// transactions, one outstanding access at a time.
module core_axi_master_bridge #(
    parameter int unsigned AXI_ADDR_WIDTH = 32,
    parameter int unsigned AXI_DATA_WIDTH = 64,
    parameter int unsigned AXI_ID_WIDTH   = 10,
    parameter int unsigned AXI_USER_WIDTH = 10,
    parameter int unsigned AXI_ID         = 0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        mem_req_i,
    output logic                        mem_gnt_o,
    input  logic [AXI_ADDR_WIDTH-1:0]   mem_addr_i,
    input  logic                        mem_we_i,
    input  logic [AXI_DATA_WIDTH/8-1:0] mem_be_i,
    input  logic [AXI_DATA_WIDTH-1:0]   mem_wdata_i,
    output logic                        mem_rvalid_o,
    output logic [AXI_DATA_WIDTH-1:0]   mem_rdata_o,
    output logic                        mem_err_o,
    AXI_BUS.Master                      master
);
    localparam int unsigned STRB_WIDTH = AXI_DATA_WIDTH / 8;
    localparam logic [2:0]  AXI_SIZE   = 3'($clog2(STRB_WIDTH));

    typedef enum logic [2:0] {IDLE, WRITE, WAIT_B, READ, WAIT_R} state_e;

    state_e                    state_q, state_d;
    logic [AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [STRB_WIDTH-1:0]     be_q, be_d;
    logic [AXI_DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                      aw_valid_q, aw_valid_d;
    logic                      w_valid_q, w_valid_d;
    logic                      ar_valid_q, ar_valid_d;
    logic                      b_ready_q, b_ready_d;
    logic                      r_ready_q, r_ready_d;
    logic                      rvalid_q, rvalid_d;
    logic                      err_q, err_d;
    logic [AXI_DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                      unused_axi;

    assign mem_gnt_o = mem_req_i && (state_q == IDLE) && !rst;

    // State and payload registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            be_q       <= '0;
            wdata_q    <= '0;
            aw_valid_q <= 1'b0;
            w_valid_q  <= 1'b0;
            ar_valid_q <= 1'b0;
            b_ready_q  <= 1'b0;
            r_ready_q  <= 1'b0;
            rvalid_q   <= 1'b0;
            err_q      <= 1'b0;
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            be_q       <= be_d;
            wdata_q    <= wdata_d;
            aw_valid_q <= aw_valid_d;
            w_valid_q  <= w_valid_d;
            ar_valid_q <= ar_valid_d;
            b_ready_q  <= b_ready_d;
            r_ready_q  <= r_ready_d;
            rvalid_q   <= rvalid_d;
            err_q      <= err_d;
            rdata_q    <= rdata_d;
        end
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        be_d       = be_q;
        wdata_d    = wdata_q;
        aw_valid_d = aw_valid_q;
        w_valid_d  = w_valid_q;
        ar_valid_d = ar_valid_q;
        b_ready_d  = b_ready_q;
        r_ready_d  = r_ready_q;
        rvalid_d   = 1'b0;
        err_d      = err_q;
        rdata_d    = rdata_q;

        unique case (state_q)
            IDLE: begin
                if (mem_req_i) begin
                    addr_d  = mem_addr_i;
                    be_d    = mem_be_i;
                    wdata_d = mem_wdata_i;
                    if (mem_we_i) begin
                        state_d    = WRITE;
                        aw_valid_d = 1'b1;
                        w_valid_d  = 1'b1;
                    end else begin
                        state_d    = READ;
                        ar_valid_d = 1'b1;
                    end
                end
            end
            WRITE: begin
                // AW and W retire independently; B is awaited once both are gone
                if (aw_valid_q && master.aw_ready) aw_valid_d = 1'b0;
                if (w_valid_q && master.w_ready)   w_valid_d  = 1'b0;
                if (!aw_valid_d && !w_valid_d) begin
                    state_d   = WAIT_B;
                    b_ready_d = 1'b1;
                end
            end
            WAIT_B: begin
                if (master.b_valid) begin
                    state_d   = IDLE;
                    b_ready_d = 1'b0;
                    rvalid_d  = 1'b1;
                    err_d     = (master.b_resp != 2'b00);
                end
            end
            READ: begin
                if (master.ar_ready) begin
                    state_d    = WAIT_R;
                    ar_valid_d = 1'b0;
                    r_ready_d  = 1'b1;
                end
            end
            WAIT_R: begin
                if (master.r_valid) begin
                    state_d   = IDLE;
                    r_ready_d = 1'b0;
                    rvalid_d  = 1'b1;
                    err_d     = (master.r_resp != 2'b00);
                    rdata_d   = master.r_data;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign mem_rvalid_o = rvalid_q;
    assign mem_err_o    = err_q;
    assign mem_rdata_o  = rdata_q;

    assign master.aw_id     = AXI_ID_WIDTH'(AXI_ID);
    assign master.aw_addr   = addr_q;
    assign master.aw_len    = 8'd0;
    assign master.aw_size   = AXI_SIZE;
    assign master.aw_burst  = 2'b01;
    assign master.aw_lock   = 1'b0;
    assign master.aw_cache  = 4'd0;
    assign master.aw_prot   = 3'd0;
    assign master.aw_region = 4'd0;
    assign master.aw_qos    = 4'd0;
    assign master.aw_user   = '0;
    assign master.aw_valid  = aw_valid_q;

    assign master.w_data    = wdata_q;
    assign master.w_strb    = be_q;
    assign master.w_last    = 1'b1;
    assign master.w_user    = '0;
    assign master.w_valid   = w_valid_q;

    assign master.b_ready   = b_ready_q;

    assign master.ar_id     = AXI_ID_WIDTH'(AXI_ID);
    assign master.ar_addr   = addr_q;
    assign master.ar_len    = 8'd0;
    assign master.ar_size   = AXI_SIZE;
    assign master.ar_burst  = 2'b01;
    assign master.ar_lock   = 1'b0;
    assign master.ar_cache  = 4'd0;
    assign master.ar_prot   = 3'd0;
    assign master.ar_region = 4'd0;
    assign master.ar_qos    = 4'd0;
    assign master.ar_user   = '0;
    assign master.ar_valid  = ar_valid_q;

    assign master.r_ready   = r_ready_q;

    // Response sideband the bridge has no use for
    assign unused_axi = ^{master.b_id, master.b_user, master.r_id,
                          master.r_last, master.r_user};
endmodule

// File: tb/tb_core_axi_master_bridge.sv
// Self-checking bench: randomized core requests and slave timing, checked every
// cycle against a transaction-level model of the bridge's obligations.
module tb_core_axi_master_bridge;
    localparam int unsigned TB_ID = 5;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [7:0]  be;
        logic [63:0] wdata;
        int          aw_dly;
        int          w_dly;
        int          ar_dly;
        int          rsp_dly;
        logic [1:0]  resp;
        logic [63:0] rdata;
        int          gap;
    } txn_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_req_i = 1'b0;
    logic        mem_gnt_o;
    logic [31:0] mem_addr_i = '0;
    logic        mem_we_i = 1'b0;
    logic [7:0]  mem_be_i = '0;
    logic [63:0] mem_wdata_i = '0;
    logic        mem_rvalid_o;
    logic [63:0] mem_rdata_o;
    logic        mem_err_o;

    AXI_BUS #(.AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(64), .AXI_ID_WIDTH(10), .AXI_USER_WIDTH(10)) bus ();

    core_axi_master_bridge #(
        .AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(64), .AXI_ID_WIDTH(10),
        .AXI_USER_WIDTH(10), .AXI_ID(TB_ID)
    ) dut (
        .clk(clk), .rst(rst),
        .mem_req_i(mem_req_i), .mem_gnt_o(mem_gnt_o), .mem_addr_i(mem_addr_i),
        .mem_we_i(mem_we_i), .mem_be_i(mem_be_i), .mem_wdata_i(mem_wdata_i),
        .mem_rvalid_o(mem_rvalid_o), .mem_rdata_o(mem_rdata_o), .mem_err_o(mem_err_o),
        .master(bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Model: pending obligations of the single outstanding transaction
    txn_t        req_q[$];
    txn_t        cur;
    bit          busy, m_aw, m_w, m_ar, m_bready, m_rready, m_cpl, rsp_arm;
    int          aw_cnt, w_cnt, ar_cnt, rsp_cnt;
    logic        m_err;
    logic [63:0] m_rdata, last_rdata;
    longint      cyc = 0;

    // Event statistics for the directed scenarios
    int          n_grant, n_cpl, grant_rv, aw_cycles, w_cycles;
    longint      grant_cyc, first_ar_cyc, cpl_cyc;
    logic [63:0] cpl_rdata;
    logic        cpl_err;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic txn_t mk(input logic we, input logic [31:0] addr, input logic [7:0] be,
                                input logic [63:0] wdata, input int awd, input int wd,
                                input int ard, input int rspd, input logic [1:0] resp,
                                input logic [63:0] rdata, input int gap);
        txn_t t;
        t.we = we; t.addr = addr; t.be = be; t.wdata = wdata;
        t.aw_dly = awd; t.w_dly = wd; t.ar_dly = ard; t.rsp_dly = rspd;
        t.resp = resp; t.rdata = rdata; t.gap = gap;
        return t;
    endfunction

    task automatic clear_stats();
        n_grant = 0; n_cpl = 0; grant_rv = 0; aw_cycles = 0; w_cycles = 0;
        grant_cyc = -1; first_ar_cyc = -1; cpl_cyc = -1;
        cpl_rdata = '0; cpl_err = 1'b0;
    endtask

    task automatic model_clear();
        busy = 0; m_aw = 0; m_w = 0; m_ar = 0; m_bready = 0; m_rready = 0;
        m_cpl = 0; rsp_arm = 0; aw_cnt = 0; w_cnt = 0; ar_cnt = 0; rsp_cnt = 0;
        m_err = 1'b0; m_rdata = '0; last_rdata = '0;
        req_q.delete();
    endtask

    task automatic slave_idle();
        bus.aw_ready = 1'b0; bus.w_ready = 1'b0; bus.ar_ready = 1'b0;
        bus.b_valid = 1'b0; bus.b_resp = 2'b00; bus.b_id = '0; bus.b_user = '0;
        bus.r_valid = 1'b0; bus.r_resp = 2'b00; bus.r_data = '0;
        bus.r_id = '0; bus.r_last = 1'b0; bus.r_user = '0;
    endtask

    // One clock cycle, entered and left at a falling edge
    task automatic cycle();
        bit granted, hs_aw, hs_w, hs_ar, hs_b, hs_r, new_cpl;
        txn_t t;
        if (req_q.size() > 0 && req_q[0].gap > 0) begin
            t = req_q[0]; t.gap = t.gap - 1; req_q[0] = t;
            mem_req_i = 1'b0;
            mem_addr_i = $urandom; mem_we_i = 1'($urandom);
        end else if (req_q.size() > 0) begin
            mem_req_i = 1'b1; mem_we_i = req_q[0].we; mem_addr_i = req_q[0].addr;
            mem_be_i = req_q[0].be; mem_wdata_i = req_q[0].wdata;
        end else begin
            mem_req_i = 1'b0; mem_addr_i = $urandom; mem_we_i = 1'($urandom);
        end

        bus.aw_ready = bus.aw_valid && (aw_cnt >= cur.aw_dly);
        bus.w_ready  = bus.w_valid && (w_cnt >= cur.w_dly);
        bus.ar_ready = bus.ar_valid && (ar_cnt >= cur.ar_dly);
        bus.b_valid  = rsp_arm && cur.we && (rsp_cnt >= cur.rsp_dly);
        bus.r_valid  = rsp_arm && !cur.we && (rsp_cnt >= cur.rsp_dly);
        bus.b_resp   = cur.resp;
        bus.r_resp   = cur.resp;
        bus.r_data   = bus.r_valid ? cur.rdata : {$urandom, $urandom};
        bus.b_id = 10'($urandom); bus.r_id = 10'($urandom); bus.r_last = 1'($urandom);
        bus.b_user = 10'($urandom); bus.r_user = 10'($urandom);
        #1;

        chk("gnt", mem_gnt_o, mem_req_i && !busy);
        chk("aw_valid", bus.aw_valid, m_aw);
        chk("w_valid", bus.w_valid, m_w);
        chk("ar_valid", bus.ar_valid, m_ar);
        chk("b_ready", bus.b_ready, m_bready);
        chk("r_ready", bus.r_ready, m_rready);
        chk("rvalid", mem_rvalid_o, m_cpl);
        if (m_cpl) begin
            chk("err", mem_err_o, m_err);
            chk("rdata", mem_rdata_o, m_rdata);
        end
        if (m_aw) begin
            chk("aw_addr", bus.aw_addr, cur.addr);
            chk("aw_id", bus.aw_id, TB_ID);
            chk("aw_len", bus.aw_len, 0);
            chk("aw_size", bus.aw_size, 3);
            chk("aw_burst", bus.aw_burst, 1);
            chk("aw_misc", {bus.aw_lock, bus.aw_cache, bus.aw_prot, bus.aw_region,
                            bus.aw_qos, bus.aw_user}, 0);
        end
        if (m_w) begin
            chk("w_data", bus.w_data, cur.wdata);
            chk("w_strb", bus.w_strb, cur.be);
            chk("w_last", bus.w_last, 1);
            chk("w_user", bus.w_user, 0);
        end
        if (m_ar) begin
            chk("ar_addr", bus.ar_addr, cur.addr);
            chk("ar_id", bus.ar_id, TB_ID);
            chk("ar_len", bus.ar_len, 0);
            chk("ar_size", bus.ar_size, 3);
            chk("ar_burst", bus.ar_burst, 1);
            chk("ar_misc", {bus.ar_lock, bus.ar_cache, bus.ar_prot, bus.ar_region,
                            bus.ar_qos, bus.ar_user}, 0);
        end

        if (mem_req_i && mem_gnt_o) begin
            n_grant++; grant_cyc = cyc; first_ar_cyc = -1;
            if (mem_rvalid_o) grant_rv++;
        end
        if (mem_rvalid_o) begin
            n_cpl++; cpl_cyc = cyc; cpl_rdata = mem_rdata_o; cpl_err = mem_err_o;
        end
        if (bus.aw_valid) aw_cycles++;
        if (bus.w_valid) w_cycles++;
        if (bus.ar_valid && first_ar_cyc < 0) first_ar_cyc = cyc;

        granted = mem_req_i && !busy;
        hs_aw = m_aw && bus.aw_ready;
        hs_w  = m_w && bus.w_ready;
        hs_ar = m_ar && bus.ar_ready;
        hs_b  = m_bready && bus.b_valid;
        hs_r  = m_rready && bus.r_valid;

        @(posedge clk);
        new_cpl = 1'b0;
        if (granted) begin
            cur = req_q.pop_front();
            busy = 1;
            if (cur.we) begin
                m_aw = 1; m_w = 1; aw_cnt = 0; w_cnt = 0;
            end else begin
                m_ar = 1; ar_cnt = 0;
            end
        end else if (busy) begin
            if (cur.we) begin
                if (m_aw || m_w) begin
                    if (m_aw) begin if (hs_aw) m_aw = 0; else aw_cnt++; end
                    if (m_w)  begin if (hs_w)  m_w  = 0; else w_cnt++;  end
                    if (!m_aw && !m_w) begin m_bready = 1; rsp_arm = 1; rsp_cnt = 0; end
                end else if (hs_b) begin
                    m_bready = 0; rsp_arm = 0; busy = 0; new_cpl = 1;
                    m_err = (cur.resp != 2'b00); m_rdata = last_rdata;
                end else begin
                    rsp_cnt++;
                end
            end else begin
                if (m_ar) begin
                    if (hs_ar) begin m_ar = 0; m_rready = 1; rsp_arm = 1; rsp_cnt = 0; end
                    else ar_cnt++;
                end else if (hs_r) begin
                    m_rready = 0; rsp_arm = 0; busy = 0; new_cpl = 1;
                    m_err = (cur.resp != 2'b00); m_rdata = cur.rdata; last_rdata = cur.rdata;
                end else begin
                    rsp_cnt++;
                end
            end
        end
        m_cpl = new_cpl;
        cyc++;
        @(negedge clk);
    endtask

    task automatic apply_reset(input int hold);
        rst = 1'b1;
        mem_req_i = 1'b1;
        slave_idle();
        #1;
        chk("rst_gnt", mem_gnt_o, 0);
        chk("rst_valids", {bus.aw_valid, bus.w_valid, bus.ar_valid, bus.b_ready, bus.r_ready}, 0);
        chk("rst_rvalid", mem_rvalid_o, 0);
        chk("rst_err", mem_err_o, 0);
        chk("rst_rdata", mem_rdata_o, 0);
        model_clear();
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); @(negedge clk);
            chk("rst_hold_rvalid", mem_rvalid_o, 0);
            chk("rst_hold_valids", {bus.aw_valid, bus.w_valid, bus.ar_valid}, 0);
        end
        rst = 1'b0;
        mem_req_i = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((req_q.size() > 0 || busy || m_cpl) && n < budget) begin
            cycle();
            n++;
        end
        chk("drain_timeout", (req_q.size() > 0 || busy || m_cpl), 0);
    endtask

    initial begin
        int n;
        cur = mk(1'b0, '0, '0, '0, 0, 0, 0, 0, 2'b00, '0, 0);
        model_clear();
        slave_idle();
        @(negedge clk);
        apply_reset(2);

        // Minimum-latency read
        clear_stats();
        req_q.push_back(mk(1'b0, 32'h0000_0040, 8'hFF, '0, 0, 0, 0, 0, 2'b00,
                           64'h0123_4567_89AB_CDEF, 0));
        drain(50);
        chk("rd_ar_latency", 64'(first_ar_cyc - grant_cyc), 1);
        chk("rd_cpl_latency", 64'(cpl_cyc - grant_cyc), 3);
        chk("rd_data_literal", cpl_rdata, 64'h0123_4567_89AB_CDEF);
        chk("rd_err_literal", cpl_err, 0);

        // Write with AW held off three cycles, W accepted at once
        clear_stats();
        req_q.push_back(mk(1'b1, 32'h0000_1000, 8'h0F, 64'hCAFE_F00D_1234_5678, 3, 0, 0, 0,
                           2'b00, '0, 0));
        drain(50);
        chk("wr_aw_cycles", aw_cycles, 4);
        chk("wr_w_cycles", w_cycles, 1);
        chk("wr_cpl_count", n_cpl, 1);
        chk("wr_cpl_latency", 64'(cpl_cyc - grant_cyc), 6);

        // Error response on a read, then an OKAY write keeps the old read data
        clear_stats();
        req_q.push_back(mk(1'b0, 32'h0000_2008, 8'hFF, '0, 0, 0, 1, 1, 2'b10,
                           64'hDEAD_BEEF_0000_1111, 0));
        drain(50);
        chk("slverr_err", cpl_err, 1);
        req_q.push_back(mk(1'b1, 32'h0000_2010, 8'hF0, 64'h1, 0, 1, 0, 2, 2'b00, '0, 0));
        drain(50);
        chk("okay_err", cpl_err, 0);
        chk("wr_rdata_held", cpl_rdata, 64'hDEAD_BEEF_0000_1111);

        // Four back-to-back alternating requests with request held high
        clear_stats();
        for (int i = 0; i < 4; i++)
            req_q.push_back(mk(1'(i % 2), 32'h100 + 32'(i * 8), 8'hFF, 64'(i + 100),
                               0, 0, 0, 0, 2'b00, 64'(i * 17 + 3), 0));
        drain(100);
        chk("b2b_grants", n_grant, 4);
        chk("b2b_cpls", n_cpl, 4);
        chk("b2b_grant_on_rvalid", grant_rv, 3);

        // Reset while waiting for B, then a clean read
        clear_stats();
        req_q.push_back(mk(1'b1, 32'h0000_3000, 8'h3C, 64'h77, 0, 0, 0, 20, 2'b00, '0, 0));
        n = 0;
        while (!m_bready && n < 20) begin cycle(); n++; end
        chk("reach_wait_b", m_bready, 1);
        cycle(); cycle();
        apply_reset(3);
        chk("rst_no_cpl", n_cpl, 0);
        req_q.push_back(mk(1'b0, 32'h0000_3008, 8'hFF, '0, 0, 0, 0, 0, 2'b00,
                           64'hA5A5_0000_FFFF_5A5A, 0));
        drain(50);
        chk("post_rst_cpls", n_cpl, 1);
        chk("post_rst_rdata", cpl_rdata, 64'hA5A5_0000_FFFF_5A5A);

        // Randomized traffic and slave timing
        for (int i = 0; i < 400; i++) begin
            req_q.push_back(mk(1'($urandom), $urandom, 8'($urandom), {$urandom, $urandom},
                               ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(0, 3)),
                               ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(0, 3)),
                               int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                               ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00,
                               {$urandom, $urandom},
                               ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(0, 2))));
        end
        drain(8000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
